blake2b_msg_pack: RTL and testbench
===================================

# blake2b_msg_pack

Upstream message-packing stage for the BLAKE2b compression core. Accepts a message as a stream of 64-bit little-endian beats and assembles it into 128-byte message blocks, m[0..15]. Each block carries the running byte counter t and the final-block flag that the core needs for its compression call. It zero-pads the final partial block and never emits a trailing empty block when the message length is a multiple of 128.

## Interface
Parameters:
- T_W, 128, width of byte counter t (BLAKE2b t is 128 bits)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, reset asynchronous and active-low
- i_dat  in  64  message beat; message byte n of the beat at i_dat[8n+:8]
- i_nbytes  in  4  valid bytes in beat, 0..8; honoured only when i_eop=1, otherwise treated as 8
- i_eop  in  1  last beat of message
- i_val  in  1  beat valid
- o_rdy  out  1  beat accepted when i_val & o_rdy
- o_blk  out  1024  message block; word k (m[k]) at o_blk[64k+:64]
- o_t  out  T_W  total message bytes up to and including this block
- o_last  out  1  block is final (core sets its final flag)
- o_val  out  1  block valid
- i_rdy  in  1  block consumed when o_val & i_rdy

## Operation
- Two 1024-bit registers:
  - fill buffer, with word index widx (0..15);
  - output register (o_blk/o_t/o_last/o_val).
- Byte counter cnt (T_W bits) adds the beat's byte count on every accepted beat; wraps modulo 2^T_W.
- Accepted beat is written to fill word widx. Bytes at positions >= i_nbytes on an eop beat are forced to zero regardless of i_dat.
- Block completes when either:
  - the 16th beat is accepted (widx=15), or
  - any eop beat is accepted.
- On completion:
  - the unwritten fill words above the final beat are zero;
  - o_last = i_eop of the completing beat;
  - o_t = updated cnt.
- Completed block moves into the output register when it is empty or being consumed in the same cycle. Otherwise it waits in the fill buffer (state PEND).
- States:
  - FILL: o_rdy=1.
  - PEND: fill buffer holds a complete block, o_rdy=0; exits to FILL on the cycle the output register frees.
- After an eop block transfers, cnt, widx and the fill buffer clear to 0 for the next message.
- 128·k-byte message: the eop arrives on the 16th beat, so that block is final; no extra block is produced.
- Empty message: a single eop beat with i_nbytes=0 produces one all-zero block, t=0, o_last=1.
- i_nbytes=0 on an eop beat that follows other beats of the same message is legal. It adds no bytes but still closes the message:
  - if the preceding beats filled the buffer (widx wrapped), it yields a block with m all zero, the unchanged t, and o_last=1;
  - otherwise it finalises the partial block.

## Timing
- Reset values: o_val=0, o_last=0, o_t=0, o_blk=0, o_rdy=1, state FILL, cnt=0, widx=0.
- Reset asserted mid-message discards all partial and pending data.
- Latency: block appears on o_val the cycle after its completing beat is accepted, provided the output register is free.
- Output register holds o_blk/o_t/o_last stable while o_val & !i_rdy.
- Throughput: full rate, one beat per cycle sustained, as long as the consumer takes a block within 16 cycles of it appearing.
- Simultaneous events:
  - completing beat + i_rdy on the occupied output register: the new block loads in the same edge, and o_val stays 1.
  - PEND + i_rdy: the transfer happens on that edge, and o_rdy=1 the following cycle.
- o_rdy is a registered, state-based output: it depends on state, not combinationally on i_val.

## Structure
- Add to the shared BLAKE2b package:
  - BLOCK_BYTES=128;
  - NUM_WORDS=16;
  - typedef msg_blk_t as logic [15:0][63:0];
  - function byte_mask(nbytes), returning a 64-bit byte-lane keep mask.
- Single flat module; no sub-module is needed.

## Test plan
- Empty message: one beat, i_eop=1, i_nbytes=0 -> one block, all zero, o_t=0, o_last=1.
- "abc": i_dat=64'hFFFFFFFFFF636261, i_nbytes=3, i_eop -> m[0]=64'h0000000000636261, m[1..15]=0, o_t=3, o_last=1.
- 128-byte message, 16 beats, eop on 16th with i_nbytes=8 -> exactly one block, o_t=128, o_last=1; no second block within 20 cycles.
- 129-byte message, 17 beats, last with i_nbytes=1 -> block A: o_t=128, o_last=0; block B: m[0]=byte 128 only, o_t=129, o_last=1.
- 300-byte stream, i_val always 1, i_rdy held low 40 cycles after first block -> o_rdy drops while the second block is PEND, o_blk stable throughout stall; three blocks with o_t=128, 256, 300, last flags 0, 0, 1; data matches the reference model.
- i_rst_n pulsed low after 5 beats of a message, then "abc" sent -> only the clean "abc" block emitted, o_t=3.

Source files
------------

// File: rtl/blake2b_msg_pack_pkg.sv
// Shared BLAKE2b definitions: block geometry, message block type and byte-lane helpers.
package blake2b_msg_pack_pkg;

  localparam int BLOCK_BYTES = 128;
  localparam int NUM_WORDS   = 16;
  localparam int WORD_BYTES  = BLOCK_BYTES / NUM_WORDS;

  typedef logic [15:0][63:0] msg_blk_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } pack_state_t;

  // Keep mask for the low nbytes byte lanes; counts above 8 keep all lanes.
  function automatic logic [63:0] byte_mask(input logic [3:0] nbytes);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i < int'(nbytes)) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/blake2b_msg_pack.sv
// Packs 64-bit little-endian message beats into 128-byte BLAKE2b blocks with
// running byte count t and final-block flag; zero-pads the last partial block.
module blake2b_msg_pack
  import blake2b_msg_pack_pkg::*;
#(
  parameter int T_W = 128
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [63:0]    i_dat,
  input  logic [3:0]     i_nbytes,
  input  logic           i_eop,
  input  logic           i_val,
  output logic           o_rdy,
  output logic [1023:0]  o_blk,
  output logic [T_W-1:0] o_t,
  output logic           o_last,
  output logic           o_val,
  input  logic           i_rdy
);

  // Handshake: a beat transfers on i_val & o_rdy, a block on o_val & i_rdy.
  // o_rdy is registered from state only; o_val/o_blk/o_t/o_last hold until taken.

  pack_state_t    r_state;
  logic           r_rdy;
  msg_blk_t       r_fill;
  logic [3:0]     r_widx;
  logic [T_W-1:0] r_cnt;
  logic           r_pend_last;
  msg_blk_t       r_out_blk;
  logic [T_W-1:0] r_out_t;
  logic           r_out_last;
  logic           r_out_val;

  logic           w_acc;
  logic [3:0]     w_nb;
  logic [63:0]    w_word;
  logic [T_W-1:0] w_cnt_nx;
  logic           w_done;
  logic           w_out_free;
  msg_blk_t       w_blk;

  assign w_acc      = i_val & r_rdy;
  assign w_nb       = i_eop ? ((i_nbytes > 4'd8) ? 4'd8 : i_nbytes) : 4'd8;
  assign w_word     = i_eop ? (i_dat & byte_mask(i_nbytes)) : i_dat;
  assign w_cnt_nx   = r_cnt + T_W'(w_nb);
  assign w_done     = w_acc & (i_eop | (r_widx == 4'(NUM_WORDS - 1)));
  assign w_out_free = ~r_out_val | i_rdy;

  // Completed block as it would look with the current beat merged in;
  // words above widx are already zero because the buffer clears per block.
  always_comb begin
    w_blk         = r_fill;
    w_blk[r_widx] = w_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_FILL;
      r_rdy       <= 1'b1;
      r_fill      <= '0;
      r_widx      <= '0;
      r_cnt       <= '0;
      r_pend_last <= 1'b0;
      r_out_blk   <= '0;
      r_out_t     <= '0;
      r_out_last  <= 1'b0;
      r_out_val   <= 1'b0;
    end else begin
      if (r_out_val && i_rdy) r_out_val <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_acc) begin
            if (w_done && w_out_free) begin
              r_out_blk   <= w_blk;
              r_out_t     <= w_cnt_nx;
              r_out_last  <= i_eop;
              r_out_val   <= 1'b1;
              r_fill      <= '0;
              r_widx      <= '0;
              r_cnt       <= i_eop ? '0 : w_cnt_nx;
            end else begin
              r_fill[r_widx] <= w_word;
              r_cnt          <= w_cnt_nx;
              if (w_done) begin
                r_state     <= ST_PEND;
                r_rdy       <= 1'b0;
                r_pend_last <= i_eop;
              end else begin
                r_widx <= r_widx + 4'd1;
              end
            end
          end
        end
        ST_PEND: begin
          if (w_out_free) begin
            r_out_blk   <= r_fill;
            r_out_t     <= r_cnt;
            r_out_last  <= r_pend_last;
            r_out_val   <= 1'b1;
            r_fill      <= '0;
            r_widx      <= '0;
            if (r_pend_last) r_cnt <= '0;
            r_pend_last <= 1'b0;
            r_state     <= ST_FILL;
            r_rdy       <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_FILL;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign o_rdy  = r_rdy;
  assign o_blk  = r_out_blk;
  assign o_t    = r_out_t;
  assign o_last = r_out_last;
  assign o_val  = r_out_val;

endmodule

// File: tb/tb_blake2b_msg_pack.sv
// Bench for blake2b_msg_pack: random messages against a byte-array block model,
// expected blocks queued at issue time and compared by a consumer-side monitor.
module tb_blake2b_msg_pack;
  import blake2b_msg_pack_pkg::*;

  localparam int T_W = 128;
  localparam int EW  = 1 + T_W + 1024;

  typedef logic [7:0] bq_t[$];

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [63:0]    i_dat = '0;
  logic [3:0]     i_nbytes = '0;
  logic           i_eop = 1'b0;
  logic           i_val = 1'b0;
  logic           o_rdy;
  logic [1023:0]  o_blk;
  logic [T_W-1:0] o_t;
  logic           o_last;
  logic           o_val;
  logic           i_rdy = 1'b0;

  blake2b_msg_pack #(.T_W(T_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dat(i_dat), .i_nbytes(i_nbytes),
    .i_eop(i_eop), .i_val(i_val), .o_rdy(o_rdy), .o_blk(o_blk), .o_t(o_t),
    .o_last(o_last), .o_val(o_val), .i_rdy(i_rdy)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  int   rdy_mode = 1;      // 0 random, 1 always ready, 2 take one block then stall 40
  int   stall_left = 0;
  bit   stall_used = 0;
  bit   saw_rdy_low = 0;
  int   blk_seen = 0;

  logic           hold_v = 1'b0;
  logic [1023:0]  hold_blk;
  logic [T_W-1:0] hold_t;
  logic           hold_last;

  task automatic check(input string name, input logic [T_W-1:0] act, input logic [T_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (act[64*k +: 64] !== exp[64*k +: 64]) begin
          $display("FAIL %s: m[%0d] got %016h expected %016h", name, k, act[64*k +: 64], exp[64*k +: 64]);
          break;
        end
      end
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_expected(input bq_t msg, input bit extra_zero);
    int n, nblk, t;
    logic [1023:0] blk;
    n = msg.size();
    nblk = (n == 0 || n % BLOCK_BYTES != 0) ? n / BLOCK_BYTES + 1 : n / BLOCK_BYTES;
    if (extra_zero && n > 0 && n % BLOCK_BYTES == 0) nblk++;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (b * BLOCK_BYTES + i < n) blk[8*i +: 8] = msg[b * BLOCK_BYTES + i];
      end
      t = (BLOCK_BYTES * (b + 1) < n) ? BLOCK_BYTES * (b + 1) : n;
      exp_q.push_back({(b == nblk - 1), T_W'(t), blk});
    end
  endtask

  // ---------------- monitor / consumer ----------------
  always @(negedge i_clk) begin
    logic r;
    logic [EW-1:0] e;
    if (!i_rst_n) begin
      i_rdy  = 1'b0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_blk("stall_blk_stable", o_blk, hold_blk);
        check("stall_t_stable", o_t, hold_t);
        check("stall_last_stable", T_W'(o_last), T_W'(hold_last));
      end
      case (rdy_mode)
        0: r = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_left > 0) begin
            r = 1'b0;
            stall_left--;
            if (!o_rdy) saw_rdy_low = 1;
          end else begin
            r = 1'b1;
          end
        end
        default: r = 1'b1;
      endcase
      i_rdy = r;
      if (o_val) blk_seen++;
      if (o_val && r) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_block: got t=%0d last=%0d expected no block", o_t, o_last);
        end else begin
          e = exp_q.pop_front();
          check_blk("blk", o_blk, e[1023:0]);
          check("t", o_t, e[1024 +: T_W]);
          check("last", T_W'(o_last), T_W'(e[EW-1]));
        end
        if (rdy_mode == 2 && !stall_used) begin
          stall_used = 1;
          stall_left = 40;
        end
      end
      hold_v    = o_val && !r;
      hold_blk  = o_blk;
      hold_t    = o_t;
      hold_last = o_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    i_val = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [3:0] nb, input logic e);
    bit ok, acc;
    i_dat = d; i_nbytes = nb; i_eop = e; i_val = 1'b1;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      acc = o_rdy;
      @(negedge i_clk);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_timeout: got no accept expected accept within 500 cycles");
    end
  endtask

  task automatic send_msg(input bq_t msg, input bit extra_zero, input bit gaps);
    int n, beats, nb_here;
    logic [63:0] d;
    logic last;
    push_expected(msg, extra_zero);
    n = msg.size();
    beats = (n + 7) / 8;
    if (beats == 0) begin
      send_beat({$urandom, $urandom}, 4'd0, 1'b1);
    end else begin
      for (int j = 0; j < beats; j++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        d = {$urandom, $urandom};
        nb_here = (n - 8 * j < 8) ? n - 8 * j : 8;
        for (int b = 0; b < nb_here; b++) d[8*b +: 8] = msg[8 * j + b];
        last = (j == beats - 1) && !extra_zero;
        send_beat(d, last ? 4'(nb_here) : 4'($urandom_range(0, 8)), last);
      end
      if (extra_zero) send_beat({$urandom, $urandom}, 4'd0, 1'b1);
    end
    i_val = 1'b0;
  endtask

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    i_val = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0 && !o_val) begin
        ok = 1;
        break;
      end
      @(negedge i_clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_drain: got %0d blocks outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_o_val"}, T_W'(o_val), '0);
    check({name, "_o_last"}, T_W'(o_last), '0);
    check({name, "_o_t"}, o_t, '0);
    check_blk({name, "_o_blk"}, o_blk, '0);
    check({name, "_o_rdy"}, T_W'(o_rdy), T_W'(1));
  endtask

  task automatic send_abc();
    bq_t abc;
    abc = {8'h61, 8'h62, 8'h63};
    push_expected(abc, 0);
    send_beat(64'hFFFFFFFFFF636261, 4'd3, 1'b1);
    i_val = 1'b0;
    check("abc_latency_o_val", T_W'(o_val), T_W'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bq_t m;
    int n;
    repeat (3) @(negedge i_clk);
    check_reset("reset");
    @(posedge i_clk); #2 i_rst_n = 1'b1;
    @(negedge i_clk);

    // empty message
    rdy_mode = 1;
    m = {};
    send_msg(m, 0, 0);
    check("empty_latency_o_val", T_W'(o_val), T_W'(1));
    wait_drain("empty");

    send_abc();
    wait_drain("abc");

    // exactly 128 bytes: one final block, nothing after it
    send_msg(rand_msg(128), 0, 0);
    wait_drain("m128");
    blk_seen = 0;
    idle(20);
    check("m128_no_extra_block", T_W'(blk_seen), '0);

    send_msg(rand_msg(129), 0, 0);
    wait_drain("m129");

    // 300-byte stream with a 40-cycle consumer stall after the first block
    stall_used = 0; stall_left = 0; saw_rdy_low = 0;
    rdy_mode = 2;
    send_msg(rand_msg(300), 0, 0);
    wait_drain("m300");
    check("m300_rdy_dropped_in_pend", T_W'(saw_rdy_low), T_W'(1));
    rdy_mode = 1;

    // zero-byte eop closing a full buffer and a partial one
    send_msg(rand_msg(128), 1, 0);
    wait_drain("m128_eop0");
    send_msg(rand_msg(24), 1, 0);
    wait_drain("m24_eop0");

    // reset mid-message discards the partial block
    send_beat({$urandom, $urandom}, 4'd8, 1'b0);
    send_beat({$urandom, $urandom}, 4'd8, 1'b0);
    send_beat({$urandom, $urandom}, 4'd8, 1'b0);
    send_beat({$urandom, $urandom}, 4'd8, 1'b0);
    send_beat({$urandom, $urandom}, 4'd8, 1'b0);
    i_val = 1'b0;
    @(posedge i_clk); #2 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    check_reset("midreset");
    @(posedge i_clk); #2 i_rst_n = 1'b1;
    @(negedge i_clk);
    send_abc();
    wait_drain("abc_after_reset");

    // random traffic with random back-pressure and beat gaps
    rdy_mode = 0;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        n = 8 * $urandom_range(0, 40);
        if ($urandom_range(0, 1) == 0) n = BLOCK_BYTES * $urandom_range(1, 3);
        send_msg(rand_msg(n), 1, 1);
      end else begin
        send_msg(rand_msg($urandom_range(0, 300)), 0, 1);
      end
    end
    wait_drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
